// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the adder-sharing arbiter: FSM states,
// default sizes, saturation limits and the signed-overflow helper.
package adder_share_arbiter_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;

    localparam logic [DEF_WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DEF_WIDTH-1:0] SAT_MIN = 32'h8000_0000;

    // Two's complement overflow: operands agree in sign, sum disagrees.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_s);
        return (sign_a == sign_b) && (sign_s != sign_a);
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request, shared-adder and result signals of the adder-sharing arbiter.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]         add_in1;
    logic [WIDTH-1:0]         add_in2;
    logic [WIDTH-1:0]         add_out1;
    logic                     res_valid;
    logic [WIDTH-1:0]         res_data;
    logic [IW-1:0]            res_id;
    logic                     res_ovf;
    logic                     res_ready;

    modport slave (
        input  req_valid, req_a, req_b, add_out1, res_ready,
        output req_ready, add_in1, add_in2, res_valid, res_data, res_id, res_ovf
    );

    modport master (
        output req_valid, req_a, req_b, add_out1, res_ready,
        input  req_ready, add_in1, add_in2, res_valid, res_data, res_id, res_ovf
    );

endinterface

// File: rtl/adder_share_arbiter_rr_grant.sv
// Combinational round-robin search: first valid requester at or above the
// pointer, wrapping around.
module rr_grant #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [IW-1:0]      i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    // Priority scan starting at the pointer position.
    always_comb begin
        int  pos;
        logic w_found;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        pos     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(i_rr_ptr) + k) % NUM_REQ;
            if (!w_found && i_req_valid[pos]) begin
                w_found      = 1'b1;
                o_idx        = IW'(pos);
                o_grant[pos] = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external adder among NUM_REQ requesters,
// with a one-deep saturating result slot.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    adder_share_arbiter_if.slave bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [WIDTH-1:0] L_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] L_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IW-1:0]    L_LAST    = IW'(NUM_REQ - 1);

    state_t             r_state, w_next_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_gnt_any;
    logic               w_can_accept;
    logic               w_accept;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_add_in1, w_add_in2, w_sum_sat;
    logic [WIDTH-1:0]   r_res_data;
    logic [IW-1:0]      r_res_id;
    logic               r_res_ovf;

    rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
        .i_req_valid (bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_gnt),
        .o_idx       (w_gnt_idx),
        .o_any       (w_gnt_any)
    );

    // Accept gating, operand steering and saturation of the adder's sum.
    always_comb begin
        w_can_accept = !rst && ((r_state == EMPTY) || bus.res_ready);
        w_accept     = w_can_accept && w_gnt_any;
        w_add_in1    = '0;
        w_add_in2    = '0;
        if (w_gnt_any) begin
            w_add_in1 = bus.req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
            w_add_in2 = bus.req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
        end else begin
            w_add_in1 = '0;
            w_add_in2 = '0;
        end
        w_ovf = add_ovf(w_add_in1[WIDTH-1], w_add_in2[WIDTH-1], bus.add_out1[WIDTH-1]);
        if (w_ovf) begin
            w_sum_sat = w_add_in1[WIDTH-1] ? L_SAT_MIN : L_SAT_MAX;
        end else begin
            w_sum_sat = bus.add_out1;
        end
    end

    // Result-slot next state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY:   w_next_state = w_accept ? FULL : EMPTY;
            FULL:    w_next_state = (w_accept || !bus.res_ready) ? FULL : EMPTY;
            default: w_next_state = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Result slot: loaded on accept, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_data <= '0;
            r_res_id   <= '0;
            r_res_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_res_data <= w_sum_sat;
            r_res_id   <= w_gnt_idx;
            r_res_ovf  <= w_ovf;
        end else begin
            r_res_data <= r_res_data;
            r_res_id   <= r_res_id;
            r_res_ovf  <= r_res_ovf;
        end
    end

    // Round-robin pointer moves past the winner on every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_gnt_idx == L_LAST) ? '0 : w_gnt_idx + IW'(1);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    assign bus.req_ready = w_can_accept ? w_gnt : '0;
    assign bus.add_in1   = w_add_in1;
    assign bus.add_in2   = w_add_in2;
    assign bus.res_valid = (r_state == FULL);
    assign bus.res_data  = r_res_data;
    assign bus.res_id    = r_res_id;
    assign bus.res_ovf   = r_res_ovf;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed scenarios then
// random traffic, compared against a transaction-level reference model.
module tb_adder_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model state
    bit          m_full;
    int          m_ptr;
    int          m_id;
    logic [31:0] m_data;
    bit          m_ovf;

    adder_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The external shared adder.
    assign bus.add_out1 = bus.add_in1 + bus.add_in2;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void sat_add(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] d, output bit o);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) begin
            d = 32'h7FFF_FFFF; o = 1'b1;
        end else if (s < -64'sd2147483648) begin
            d = 32'h8000_0000; o = 1'b1;
        end else begin
            d = s[31:0]; o = 1'b0;
        end
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'h7FFF_FF00 | 32'($urandom_range(0, 255));
            2:       return 32'h8000_0000 | 32'($urandom_range(0, 255));
            default: return 32'($signed($urandom_range(0, 2000)) - 1000);
        endcase
    endfunction

    // One clock: check combinational handshake, then the registered result.
    task automatic cycle();
        int          g;
        bit          found, can, acc, o;
        logic [3:0]  exp_rdy;
        logic [31:0] d;
        @(negedge clk);
        found = 1'b0;
        g     = 0;
        o     = 1'b0;
        d     = 32'h0;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req_valid[(m_ptr + k) % N]) begin
                found = 1'b1;
                g     = (m_ptr + k) % N;
            end
        end
        can     = !rst && (!m_full || bus.res_ready);
        acc     = can && found;
        exp_rdy = acc ? 4'(1 << g) : 4'b0000;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        if (found) begin
            chk("add_in1", 64'(bus.add_in1), 64'(bus.req_a[g*W +: W]));
            chk("add_in2", 64'(bus.add_in2), 64'(bus.req_b[g*W +: W]));
        end
        if (acc) sat_add(bus.req_a[g*W +: W], bus.req_b[g*W +: W], d, o);
        @(posedge clk);
        #1;
        if (rst) begin
            m_full = 1'b0; m_ptr = 0; m_id = 0; m_data = 32'h0; m_ovf = 1'b0;
            chk("rst_data", 64'(bus.res_data), 64'h0);
            chk("rst_id",   64'(bus.res_id),   64'h0);
            chk("rst_ovf",  64'(bus.res_ovf),  64'h0);
        end else if (acc) begin
            m_full = 1'b1; m_data = d; m_ovf = o; m_id = g; m_ptr = (g + 1) % N;
        end else if (bus.res_ready) begin
            m_full = 1'b0;
        end
        chk("res_valid", 64'(bus.res_valid), 64'(m_full));
        if (m_full) begin
            chk("res_data", 64'(bus.res_data), 64'(m_data));
            chk("res_id",   64'(bus.res_id),   64'(m_id));
            chk("res_ovf",  64'(bus.res_ovf),  64'(m_ovf));
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        m_full = 1'b0; m_ptr = 0; m_id = 0; m_data = 32'h0; m_ovf = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Single request
        set_req(1, 32'd100, 32'(-30));
        bus.req_valid = 4'b0010;
        cycle();
        chk("single_data", 64'(bus.res_data), 64'd70);
        chk("single_id",   64'(bus.res_id),   64'd1);
        chk("single_ovf",  64'(bus.res_ovf),  64'd0);
        bus.req_valid = 4'b0000;
        cycle();

        // Positive overflow
        set_req(0, 32'h7FFF_FFF0, 32'h0000_0020);
        bus.req_valid = 4'b0001;
        cycle();
        chk("pos_ovf_data", 64'(bus.res_data), 64'h7FFF_FFFF);
        chk("pos_ovf_flag", 64'(bus.res_ovf),  64'd1);
        bus.req_valid = 4'b0000;
        cycle();

        // Negative overflow
        set_req(3, 32'h8000_0000, 32'hFFFF_FFFF);
        bus.req_valid = 4'b1000;
        cycle();
        chk("neg_ovf_data", 64'(bus.res_data), 64'h8000_0000);
        chk("neg_ovf_flag", 64'(bus.res_ovf),  64'd1);
        bus.req_valid = 4'b0000;
        cycle();

        // Fairness from a fresh pointer
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'(i * 10), 32'(i + 1));
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("fair_id",    64'(bus.res_id),    64'(i % N));
            chk("fair_valid", 64'(bus.res_valid), 64'd1);
        end

        // Backpressure, then release with same-cycle accept
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        bus.res_ready = 1'b1;
        cycle();
        chk("release_id", 64'(bus.res_id), 64'd0);

        // Reset while FULL after req 2 won (pointer would sit at 3)
        bus.req_valid = 4'b0100;
        cycle();
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b1100;
        rst = 1'b1;
        cycle();
        chk("rst_mid_valid", 64'(bus.res_valid), 64'd0);
        rst = 1'b0;
        bus.res_ready = 1'b1;
        cycle();
        chk("rst_mid_winner", 64'(bus.res_id), 64'd2);

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
            bus.req_valid = 4'($urandom_range(0, 15));
            bus.res_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
